// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter and its LSU result buffer.
package regfile_wb_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    // x0 is hard-wired, so a write or dependency on it never counts.
    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr != REG_X0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO buffering LSU write-back results; full/empty come from extra pointer MSB.
module regfile_wb_arbiter_wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W + XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and storage update; a push into a full buffer is ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {(AW + 1){1'b0}};
            r_rd_ptr <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback and buffered LSU results,
// with a starvation guard and a scoreboard that stalls issue on outstanding long writes.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_pipe_wb_valid,
    input  logic [REG_ADDR_W-1:0] i_pipe_wb_addr,
    input  logic [XLEN-1:0]       i_pipe_wb_data,
    input  logic                  i_lsu_wb_valid,
    output logic                  o_lsu_wb_ready,
    input  logic [REG_ADDR_W-1:0] i_lsu_wb_addr,
    input  logic [XLEN-1:0]       i_lsu_wb_data,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rs1,
    input  logic [REG_ADDR_W-1:0] i_issue_rs2,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_issue_long,
    output logic                  o_hazard_stall,
    output logic                  o_pipe_hold,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_addr,
    output logic [XLEN-1:0]       o_rf_data
);

    localparam int ENT_W = REG_ADDR_W + XLEN;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 32'sd1);

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic [ENT_W-1:0]      w_head;
    logic [REG_ADDR_W-1:0] w_head_addr;
    logic [XLEN-1:0]       w_head_data;
    logic                  w_pipe_req;
    logic                  w_grant_fifo;
    logic                  w_grant_pipe;
    logic                  w_blocked;
    logic                  w_hold_nxt;
    logic                  w_hazard;
    logic                  w_set_pend;
    logic                  w_clr_pend;
    logic [CNT_W-1:0]      w_starve_nxt;
    logic [NUM_REGS-1:0]   w_pending_nxt;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_pipe_hold;
    logic [NUM_REGS-1:0]   r_pending;

    assign {w_head_addr, w_head_data} = w_head;

    // A held WB stage yields to the buffer; x0 pipeline writes never claim the port.
    assign w_pipe_req     = i_pipe_wb_valid && is_real_reg(i_pipe_wb_addr);
    assign w_grant_fifo   = !w_fifo_empty && (r_pipe_hold || !w_pipe_req);
    assign w_grant_pipe   = w_pipe_req && !w_grant_fifo;
    assign w_blocked      = !w_fifo_empty && !w_grant_fifo;
    assign w_push         = i_lsu_wb_valid && !w_fifo_full;
    assign o_lsu_wb_ready = !w_fifo_full;
    assign o_pipe_hold    = r_pipe_hold;

    regfile_wb_arbiter_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .i_clk   (i_clock),
        .i_rst_n (i_reset_n),
        .i_push  (w_push),
        .i_pop   (w_grant_fifo),
        .i_data  ({i_lsu_wb_addr, i_lsu_wb_data}),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Write-port mux; an x0 buffer entry still pops but drives no write.
    always_comb begin
        o_rf_we   = 1'b0;
        o_rf_addr = i_pipe_wb_addr;
        o_rf_data = i_pipe_wb_data;
        if (w_grant_fifo) begin
            o_rf_we   = is_real_reg(w_head_addr);
            o_rf_addr = w_head_addr;
            o_rf_data = w_head_data;
        end else begin
            o_rf_we   = w_grant_pipe;
        end
    end

    assign w_hazard = i_issue_valid &&
                      ((r_pending[i_issue_rs1] && is_real_reg(i_issue_rs1)) ||
                       (r_pending[i_issue_rs2] && is_real_reg(i_issue_rs2)) ||
                       (r_pending[i_issue_rd]  && is_real_reg(i_issue_rd)));
    assign o_hazard_stall = w_hazard;
    assign w_set_pend = i_issue_valid && !w_hazard && i_issue_long && is_real_reg(i_issue_rd);
    assign w_clr_pend = w_grant_fifo && is_real_reg(w_head_addr);

    // Scoreboard next state; a clear beats a same-cycle set of the same register.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_clr_pend && (w_head_addr == REG_ADDR_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end else if (w_set_pend && (i_issue_rd == REG_ADDR_W'(i))) begin
                w_pending_nxt[i] = 1'b1;
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end
        end
    end

    // Starvation counter; the limit-th consecutive blocked cycle schedules a one-cycle hold.
    always_comb begin
        w_hold_nxt   = 1'b0;
        w_starve_nxt = CNT_ZERO;
        if (w_blocked && (r_starve_cnt == CNT_LAST)) begin
            w_hold_nxt   = 1'b1;
            w_starve_nxt = CNT_ZERO;
        end else if (w_blocked) begin
            w_starve_nxt = r_starve_cnt + CNT_ONE;
        end else begin
            w_starve_nxt = CNT_ZERO;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve_cnt <= CNT_ZERO;
            r_pipe_hold  <= 1'b0;
            r_pending    <= {NUM_REGS{1'b0}};
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_pipe_hold  <= w_hold_nxt;
            r_pending    <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pv, lv, iv, il;
    logic [4:0]  pa, la, rs1, rs2, rd;
    logic [31:0] pd, ld;
    logic        ready, haz, hold, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_pipe_wb_valid(pv), .i_pipe_wb_addr(pa), .i_pipe_wb_data(pd),
        .i_lsu_wb_valid(lv), .o_lsu_wb_ready(ready), .i_lsu_wb_addr(la), .i_lsu_wb_data(ld),
        .i_issue_valid(iv), .i_issue_rs1(rs1), .i_issue_rs2(rs2), .i_issue_rd(rd),
        .i_issue_long(il), .o_hazard_stall(haz), .o_pipe_hold(hold),
        .o_rf_we(we), .o_rf_addr(waddr), .o_rf_data(wdata)
    );

    // Reference model state
    ent_t        m_q[$];
    bit [31:0]   m_pend;
    int          m_run;
    bit          m_hold;
    bit          m_last_hold;
    bit          m_last_ready;
    logic [4:0]  wr_log[$];

    logic        obs_we, obs_ready, obs_haz, obs_hold;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pv = 1'b0; pa = 5'd0; pd = 32'd0;
        lv = 1'b0; la = 5'd0; ld = 32'd0;
        iv = 1'b0; il = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 32'd0;
        m_run = 0;
        m_hold = 1'b0;
        m_last_hold = 1'b0;
        m_last_ready = 1'b1;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic step();
        bit          fifo_sel, pipe_sel, e_we, e_ready, e_haz, blocked, has_head;
        logic [4:0]  e_addr, h_a;
        logic [31:0] e_data, h_d;
        ent_t        e;
        #1;
        has_head = (m_q.size() != 0);
        h_a = has_head ? m_q[0].a : 5'd0;
        h_d = has_head ? m_q[0].d : 32'd0;
        e_ready  = (m_q.size() < DEPTH);
        e_haz    = iv && ((m_pend[rs1] && rs1 != 5'd0) || (m_pend[rs2] && rs2 != 5'd0) ||
                          (m_pend[rd] && rd != 5'd0));
        fifo_sel = has_head && (m_hold || !(pv && pa != 5'd0));
        pipe_sel = !fifo_sel && pv && pa != 5'd0;
        e_we     = fifo_sel ? (h_a != 5'd0) : pipe_sel;
        e_addr   = fifo_sel ? h_a : pa;
        e_data   = fifo_sel ? h_d : pd;
        obs_we = we; obs_ready = ready; obs_haz = haz; obs_hold = hold;
        obs_addr = waddr; obs_data = wdata;
        chk("lsu_ready", ready, e_ready);
        chk("hazard_stall", haz, e_haz);
        chk("pipe_hold", hold, m_hold);
        chk("rf_we", we, e_we);
        if (e_we) begin
            chk("rf_addr", waddr, e_addr);
            chk("rf_data", wdata, e_data);
        end
        if (we) wr_log.push_back(waddr);
        @(posedge clk);
        if (iv && !e_haz && il && rd != 5'd0) m_pend[rd] = 1'b1;
        if (fifo_sel && h_a != 5'd0) m_pend[h_a] = 1'b0;
        blocked = has_head && !fifo_sel;
        if (fifo_sel) void'(m_q.pop_front());
        if (lv && e_ready) begin
            e.a = la; e.d = ld;
            m_q.push_back(e);
        end
        m_last_hold  = m_hold;
        m_last_ready = e_ready;
        m_run  = blocked ? m_run + 1 : 0;
        m_hold = (m_run == LIMIT);
        if (m_hold) m_run = 0;
        @(negedge clk);
    endtask

    task automatic next_pipe();
        if (!m_last_hold) begin
            pa = (pa >= 5'd8 || pa == 5'd0) ? 5'd1 : pa + 5'd1;
            pd = pd + 32'd1;
        end
    endtask

    initial begin
        int first_hold;
        logic [4:0] hold_addr;
        logic [4:0] lsu_seen[$];

        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rf_we", we, 1'b0);
        chk("rst_pipe_hold", hold, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_hazard", haz, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // LSU-only write lands one cycle after the push
        lv = 1'b1; la = 5'd7; ld = 32'hDEADBEEF;
        step();
        lv = 1'b0;
        step();
        chk("t2_we", obs_we, 1'b1);
        chk("t2_addr", obs_addr, 5'd7);
        chk("t2_data", obs_data, 32'hDEADBEEF);

        // RAW stall on an outstanding long write to x3
        iv = 1'b1; il = 1'b1; rd = 5'd3;
        step();
        il = 1'b0; rs1 = 5'd3; rd = 5'd4;
        step();
        chk("t4_stall_a", obs_haz, 1'b1);
        lv = 1'b1; la = 5'd3; ld = 32'h3333;
        step();
        chk("t4_stall_b", obs_haz, 1'b1);
        lv = 1'b0;
        step();
        chk("t4_stall_on_write", obs_haz, 1'b1);
        chk("t4_write_addr", obs_addr, 5'd3);
        step();
        chk("t4_release", obs_haz, 1'b0);
        idle();
        step();

        // Starvation: buffered x9 waits behind continuous pipe writes
        pv = 1'b1; pa = 5'd1; pd = 32'h101; lv = 1'b1; la = 5'd9; ld = 32'h55;
        step();
        lv = 1'b0;
        first_hold = -1;
        hold_addr = 5'd0;
        for (int k = 0; k < 8; k++) begin
            next_pipe();
            step();
            if (obs_hold && first_hold < 0) begin
                first_hold = k;
                hold_addr = obs_addr;
            end
        end
        chk("t3_hold_cycle", 64'(first_hold), 64'd4);
        chk("t3_hold_addr", hold_addr, 5'd9);
        idle();
        step();

        // Back-to-back LSU pushes against a busy pipe; third valid sees full
        wr_log.delete();
        pv = 1'b1; pa = 5'd1; pd = 32'h200;
        lv = 1'b1; la = 5'd10; ld = 32'hA0;
        step();
        next_pipe(); la = 5'd11; ld = 32'hB0;
        step();
        next_pipe(); la = 5'd12; ld = 32'hC0;
        step();
        chk("t5_ready_third", obs_ready, 1'b0);
        for (int k = 0; k < 24; k++) begin
            next_pipe();
            if (lv && m_last_ready) lv = 1'b0;
            step();
        end
        pv = 1'b0;
        lv = 1'b0;
        repeat (4) step();
        foreach (wr_log[i]) begin
            if (wr_log[i] >= 5'd10 && wr_log[i] <= 5'd12) lsu_seen.push_back(wr_log[i]);
        end
        chk("t5_count", 64'(lsu_seen.size()), 64'd3);
        if (lsu_seen.size() == 3) begin
            chk("t5_order0", lsu_seen[0], 5'd10);
            chk("t5_order1", lsu_seen[1], 5'd11);
            chk("t5_order2", lsu_seen[2], 5'd12);
        end

        // x0 writes from both sources never assert rf_we, x0 entry still pops
        idle();
        pv = 1'b1; pa = 5'd0; pd = 32'hBAD0; lv = 1'b1; la = 5'd0; ld = 32'hBAD1;
        step();
        chk("t6_we_pipe_x0", obs_we, 1'b0);
        lv = 1'b0;
        step();
        chk("t6_we_fifo_x0", obs_we, 1'b0);
        pv = 1'b0; lv = 1'b1; la = 5'd15; ld = 32'hF00D;
        step();
        lv = 1'b0;
        step();
        chk("t6_popped_we", obs_we, 1'b1);
        chk("t6_popped_addr", obs_addr, 5'd15);

        // Reset mid-run with two buffered entries and x5 pending
        idle();
        pv = 1'b1; pa = 5'd2; lv = 1'b1; la = 5'd12; ld = 32'h12;
        iv = 1'b1; il = 1'b1; rd = 5'd5;
        step();
        iv = 1'b0; il = 1'b0; rd = 5'd0; pa = 5'd3; la = 5'd13; ld = 32'h13;
        step();
        idle();
        iv = 1'b1; rs1 = 5'd5;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_rst_we", we, 1'b0);
        chk("t1_rst_hold", hold, 1'b0);
        chk("t1_rst_ready", ready, 1'b1);
        chk("t1_rst_hazard", haz, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_no_stall_x5", obs_haz, 1'b0);
        chk("t1_ready_after", obs_ready, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!m_last_hold) begin
                pv = ($urandom_range(0, 3) != 0);
                pa = 5'($urandom_range(0, 31));
                pd = $urandom;
            end
            if (!(lv && !m_last_ready)) begin
                lv = ($urandom_range(0, 2) == 0);
                la = 5'($urandom_range(0, 7));
                ld = $urandom;
            end
            iv  = ($urandom_range(0, 1) == 1);
            il  = ($urandom_range(0, 1) == 1);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
